aes_round_ctrl: RTL

Per-block sequencing FSM for the AES-128 encrypt datapath. Accepts a block-start handshake and steps the datapath through the initial AddRoundKey, the middle rounds and the final round. It then presents a result-valid handshake. On each accepted result it issues a one-cycle count_enable pulse to the downstream block-count flex_counter, and mirrors that counter's done_flag as batch_done.

---
 rtl/aes_ctrl_pkg.sv | 21 ++
 rtl/aes_round_cnt.sv | 36 +++
 rtl/aes_round_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared types and constants for the AES-128 round sequencer.
//   ctrl_state_t  : FSM state encoding used by aes_round_ctrl.
//   AES128_ROUNDS : round count after the initial AddRoundKey for AES-128.
// -----------------------------------------------------------------------------
package aes_ctrl_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_ADD = 3'd1,
    SUB      = 3'd2,
    SHIFT    = 3'd3,
    MIX      = 3'd4,
    ADD      = 3'd5,
    DONE     = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/aes_round_cnt.sv
// -----------------------------------------------------------------------------
// aes_round_cnt
// Round index register for the AES round sequencer. The index selects the
// key-schedule word and is bounded by the controller, so it never wraps.
// Ports:
//   i_clk    : system clock, rising edge
//   i_n_rst  : asynchronous active-low reset (index -> 0)
//   i_clr    : synchronous clear to 0 (wins over i_inc)
//   i_inc    : synchronous increment by 1
//   o_cnt    : current round index, RND_BITS wide
// -----------------------------------------------------------------------------
module aes_round_cnt #(
  parameter int RND_BITS = 4
) (
  input  logic                i_clk,
  input  logic                i_n_rst,
  input  logic                i_clr,
  input  logic                i_inc,
  output logic [RND_BITS-1:0] o_cnt
);

  logic [RND_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + RND_BITS'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Per-block sequencing FSM for the AES-128 encrypt datapath. Steps the
// datapath through the initial AddRoundKey, NUM_ROUNDS-1 full rounds and a
// final round without MixColumns, then offers the result.
//
// Handshakes (both strict valid/ready):
//   start/ready         : a block begins on a cycle with start=1 and ready=1;
//                         ready is high only in IDLE, start at other times is
//                         dropped, never queued.
//   out_valid/out_ready : out_valid is held until a cycle with out_ready=1;
//                         that cycle is the transfer and also pulses
//                         count_enable for the downstream block counter.
//
// Ports:
//   clk, n_rst      : clock (rising edge), asynchronous active-low reset
//   start, ready    : block-start handshake
//   out_valid, out_ready : result handshake
//   sub_bytes_en, shift_rows_en, mix_cols_en, add_key_en : one-hot
//                     datapath strobes, Moore decodes of the state
//   round_idx       : current round number / key-schedule index
//   count_enable    : one-cycle pulse per accepted result
//   done_flag       : batch-count reached, from the flex_counter
//   batch_done      : done_flag registered by one cycle
//   o_dbg_state     : current FSM state, for observation only
//
// Optional feature, macro AES_ROUND_CTRL_STALL_EN: adds input stall, which
// freezes state and round_idx and blanks all strobes in every state except
// IDLE and DONE.
// -----------------------------------------------------------------------------
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int RND_BITS   = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  output logic                ready,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                sub_bytes_en,
  output logic                shift_rows_en,
  output logic                mix_cols_en,
  output logic                add_key_en,
  output logic [RND_BITS-1:0] round_idx,
  output logic                count_enable,
  input  logic                done_flag,
  output logic                batch_done,
`ifdef AES_ROUND_CTRL_STALL_EN
  input  logic                stall,
`endif
  output ctrl_state_t         o_dbg_state
);

  localparam logic [RND_BITS-1:0] LP_LAST = RND_BITS'(NUM_ROUNDS);

  ctrl_state_t         r_state;
  ctrl_state_t         w_next;
  logic                w_clr;
  logic                w_inc;
  logic                w_adv;
  logic                w_last;
  logic [RND_BITS-1:0] w_round;
  logic                r_batch_done;

`ifdef AES_ROUND_CTRL_STALL_EN
  assign w_adv = ~stall;
`else
  assign w_adv = 1'b1;
`endif

  assign w_last = (w_round == LP_LAST);

  aes_round_cnt #(
    .RND_BITS (RND_BITS)
  ) u_round_cnt (
    .i_clk   (clk),
    .i_n_rst (n_rst),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_cnt   (w_round)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // w_adv only matters in the round states; IDLE and DONE never look at it.
  always_comb begin
    w_next        = r_state;
    w_clr         = 1'b0;
    w_inc         = 1'b0;
    ready         = 1'b0;
    out_valid     = 1'b0;
    count_enable  = 1'b0;
    sub_bytes_en  = 1'b0;
    shift_rows_en = 1'b0;
    mix_cols_en   = 1'b0;
    add_key_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next = INIT_ADD;
          w_clr  = 1'b1;
        end
      end
      INIT_ADD: begin
        add_key_en = w_adv;
        if (w_adv) begin
          w_next = SUB;
          w_inc  = 1'b1;
        end
      end
      SUB: begin
        sub_bytes_en = w_adv;
        if (w_adv) w_next = SHIFT;
      end
      SHIFT: begin
        shift_rows_en = w_adv;
        // The final round skips MixColumns.
        if (w_adv) w_next = w_last ? ADD : MIX;
      end
      MIX: begin
        mix_cols_en = w_adv;
        if (w_adv) w_next = ADD;
      end
      ADD: begin
        add_key_en = w_adv;
        if (w_adv) begin
          if (w_last) begin
            w_next = DONE;
          end else begin
            w_next = SUB;
            w_inc  = 1'b1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next       = IDLE;
          count_enable = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= done_flag;
    end
  end

  assign batch_done  = r_batch_done;
  assign round_idx   = w_round;
  assign o_dbg_state = r_state;

endmodule
